// File: rtl/rom_access_arbiter_pkg.sv
// Shared types and default sizes for the ROM access arbiter.
package rom_arb_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_ADDR_W  = 8;
    localparam int DEF_DATA_W  = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        READ = 2'd1,
        RESP = 2'd2
    } arb_state_e;

endpackage

// File: rtl/rom_access_arbiter_if.sv
// Requester, response and ROM-side signals of the ROM access arbiter.
interface rom_access_arbiter_if
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
);
    localparam int IDX_W = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ-1:0]        req_lock;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [DATA_W-1:0]         rsp_data;
    logic [NUM_REQ-1:0]        rsp_ready;
    logic [ADDR_W-1:0]         rom_addr;
    logic [DATA_W-1:0]         rom_data;
    logic [IDX_W-1:0]          gnt_id;

    modport master (
        output req_valid, req_addr, req_lock, rsp_ready,
        input  req_ready, rsp_valid, rsp_data, gnt_id
    );

    modport slave (
        input  req_valid, req_addr, req_lock, rsp_ready, rom_data,
        output req_ready, rsp_valid, rsp_data, rom_addr, gnt_id
    );

    modport rom (
        input  rom_addr,
        output rom_data
    );

endinterface

// File: rtl/rom_access_arbiter_rr_picker.sv
// Combinational round-robin picker: searches from (i_last+1) mod NUM_REQ upward.
module rr_picker #(
    parameter  int NUM_REQ = 4,
    localparam int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [IDX_W-1:0]   i_last,
    output logic [NUM_REQ-1:0] o_gnt,
    output logic [IDX_W-1:0]   o_idx,
    output logic               o_any
);

    // Walk candidates farthest-first so the nearest requester after i_last wins.
    always_comb begin
        o_idx = '0;
        o_any = |i_req;
        for (int k = NUM_REQ; k >= 1; k--) begin
            o_idx = i_req[IDX_W'((int'(i_last) + k) % NUM_REQ)]
                  ? IDX_W'((int'(i_last) + k) % NUM_REQ) : o_idx;
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            o_gnt[i] = o_any && (o_idx == IDX_W'(i));
        end
    end

endmodule

// File: rtl/rom_access_arbiter.sv
// Round-robin arbiter sharing one combinational 256x8 ROM between NUM_REQ requesters.
// Optional grant locking (req_lock) is compiled in with ROM_ARB_LOCK_EN.
module rom_access_arbiter
    import rom_arb_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int DATA_W  = DEF_DATA_W
) (
    input logic                 clk,
    input logic                 rst_n,
    rom_access_arbiter_if.slave bus
);
    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e          r_state;
    arb_state_e          w_next_state;
    logic [IDX_W-1:0]    r_gnt_id;
    logic [IDX_W-1:0]    r_last_grant;
    logic [IDX_W-1:0]    w_pick_idx;
    logic [NUM_REQ-1:0]  w_pick_req;
    logic [NUM_REQ-1:0]  w_pick_gnt;
    logic [NUM_REQ-1:0]  w_req_ready;
    logic [NUM_REQ-1:0]  w_gnt_oh;
    logic [NUM_REQ-1:0]  r_rsp_valid;
    logic                w_pick_any;
    logic                w_accept;
    logic                w_rsp_hs;
    logic                w_lock;
    logic [ADDR_W-1:0]   r_rom_addr;
    logic [ADDR_W-1:0]   w_addr_arr [NUM_REQ];
    logic [DATA_W-1:0]   r_rsp_data;

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_req
        assign w_addr_arr[g] = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_gnt_oh[g]   = (r_gnt_id == IDX_W'(g));
    end

    // While locked only the held requester is eligible, so the arbiter idles if it is silent.
    assign w_pick_req = w_lock ? (bus.req_valid & w_gnt_oh) : bus.req_valid;
    assign w_rsp_hs   = (r_state == RESP) && bus.rsp_ready[r_gnt_id];

    rr_picker #(.NUM_REQ(NUM_REQ)) u_picker (
        .i_req  (w_pick_req),
        .i_last (r_last_grant),
        .o_gnt  (w_pick_gnt),
        .o_idx  (w_pick_idx),
        .o_any  (w_pick_any)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic and the request-side ready.
    always_comb begin
        w_next_state = r_state;
        w_req_ready  = '0;
        w_accept     = 1'b0;
        case (r_state)
            IDLE: begin
                w_req_ready  = w_pick_gnt;
                w_accept     = w_pick_any;
                w_next_state = w_pick_any ? READ : IDLE;
            end
            READ:    w_next_state = RESP;
            RESP:    w_next_state = w_rsp_hs ? IDLE : RESP;
            default: w_next_state = IDLE;
        endcase
    end

    // Address capture on accept, ROM data capture in READ, response valid until handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rom_addr   <= '0;
            r_gnt_id     <= '0;
            r_last_grant <= IDX_W'(NUM_REQ - 1);
            r_rsp_valid  <= '0;
            r_rsp_data   <= '0;
        end else begin
            if (w_accept) begin
                r_rom_addr   <= w_addr_arr[w_pick_idx];
                r_gnt_id     <= w_pick_idx;
                r_last_grant <= w_pick_idx;
            end
            if (r_state == READ) begin
                r_rsp_data  <= bus.rom_data;
                r_rsp_valid <= w_gnt_oh;
            end else if (w_rsp_hs) begin
                r_rsp_valid <= '0;
            end
        end
    end

`ifdef ROM_ARB_LOCK_EN
    logic r_lock;

    // Lock follows the granted requester's req_lock at each response handshake.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_lock <= 1'b0;
        end else if (w_rsp_hs) begin
            r_lock <= bus.req_lock[r_gnt_id];
        end
    end

    assign w_lock = r_lock;
`else
    logic w_unused_lock;
    assign w_unused_lock = ^bus.req_lock;
    assign w_lock        = 1'b0;
`endif

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_data  = r_rsp_data;
    assign bus.rom_addr  = r_rom_addr;
    assign bus.gnt_id    = r_gnt_id;

endmodule

// File: tb/tb_rom_access_arbiter.sv
// Self-checking bench for rom_access_arbiter: vector table, corner sequences, random traffic.
module tb_rom_access_arbiter;
    localparam int NR = 4;
    localparam int AW = 8;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_cmp = 0;
    int   n_err = 0;

    rom_access_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus();

    rom_access_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] rom_fn(input logic [7:0] a);
        logic [15:0] p;
        p = {8'd0, a} * 16'd37;
        return p[7:0] ^ 8'h5A;
    endfunction

    assign bus.rom_data = rom_fn(bus.rom_addr);

    function automatic logic [3:0] oh(input int w);
        logic [3:0] r;
        r = 4'b0000;
        if (w >= 0) r[w] = 1'b1;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Entered 2 time units after an edge with the DUT idle and inputs applied.
    task automatic run_txn(input int win, input logic [7:0] a, input string tag);
        chk({tag, "_req_ready"}, 32'(bus.req_ready), 32'(oh(win)));
        tick(); #1;
        chk({tag, "_rom_addr"}, 32'(bus.rom_addr), 32'(a));
        chk({tag, "_gnt_id"}, 32'(bus.gnt_id), win);
        chk({tag, "_rsp_valid_read"}, 32'(bus.rsp_valid), 32'd0);
        chk({tag, "_req_ready_read"}, 32'(bus.req_ready), 32'd0);
        tick(); #1;
        chk({tag, "_rsp_valid"}, 32'(bus.rsp_valid), 32'(oh(win)));
        chk({tag, "_rsp_data"}, 32'(bus.rsp_data), 32'(rom_fn(a)));
        chk({tag, "_req_ready_resp"}, 32'(bus.req_ready), 32'd0);
        tick();
    endtask

    typedef struct {
        logic [3:0]  valid;
        logic [31:0] addrs;
        int          win;
    } vec_t;

    vec_t vecs[12];
    int   exp_lock[4];

    initial begin
        logic [31:0] av;
        logic [3:0]  rv;
        int          n1;
        int          m_last;
        int          phase;
        int          m_win;
        int          win;
        int          cnd;
        logic [7:0]  m_addr;

        vecs[0]  = '{4'b0001, 32'h0000_0010, 0};
        vecs[1]  = '{4'b1111, 32'hFF80_0100, 1};
        vecs[2]  = '{4'b1111, 32'hFF80_0100, 2};
        vecs[3]  = '{4'b1111, 32'hFF80_0100, 3};
        vecs[4]  = '{4'b1111, 32'h1234_5600, 0};
        vecs[5]  = '{4'b1111, 32'h1234_5678, 1};
        vecs[6]  = '{4'b1000, 32'hC300_0000, 3};
        vecs[7]  = '{4'b1001, 32'hAA00_0055, 0};
        vecs[8]  = '{4'b1001, 32'hAA00_0055, 3};
        vecs[9]  = '{4'b0110, 32'h007E_E700, 1};
        vecs[10] = '{4'b0100, 32'h007E_E700, 2};
        vecs[11] = '{4'b0011, 32'h0000_2112, 0};
`ifdef ROM_ARB_LOCK_EN
        exp_lock = '{1, 1, 1, 2};
`else
        exp_lock = '{1, 2, 1, 2};
`endif

        bus.req_valid = 4'b0000;
        bus.req_addr  = 32'h0;
        bus.req_lock  = 4'b0000;
        bus.rsp_ready = 4'b1111;

        // Reset values
        repeat (2) @(posedge clk);
        #1;
        chk("rst_rom_addr", 32'(bus.rom_addr), 32'd0);
        chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rst_rsp_data", 32'(bus.rsp_data), 32'd0);
        chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
        chk("rst_req_ready", 32'(bus.req_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Vector table: single transactions with rsp_ready tied high
        for (int i = 0; i < 12; i++) begin
            bus.req_valid = vecs[i].valid;
            bus.req_addr  = vecs[i].addrs;
            av = vecs[i].addrs;
            #1;
            run_txn(vecs[i].win, av[vecs[i].win*8 +: 8], $sformatf("vec%0d", i));
        end

        // Requester 2 response stalled for 5 cycles
        bus.req_valid = 4'b0100;
        bus.req_addr  = 32'h00A5_0000;
        bus.rsp_ready = 4'b1011;
        #1;
        chk("stall_req_ready", 32'(bus.req_ready), 32'(4'b0100));
        tick(); #1;
        chk("stall_rom_addr", 32'(bus.rom_addr), 32'h0000_00A5);
        tick();
        bus.req_valid = 4'b1111;
        #1;
        for (int s = 0; s < 5; s++) begin
            chk("stall_rsp_valid", 32'(bus.rsp_valid), 32'(4'b0100));
            chk("stall_rsp_data", 32'(bus.rsp_data), 32'(rom_fn(8'hA5)));
            chk("stall_req_ready_0", 32'(bus.req_ready), 32'd0);
            tick(); #1;
        end
        bus.rsp_ready = 4'b1111;
        #1;
        chk("stall_hs_rsp_valid", 32'(bus.rsp_valid), 32'(4'b0100));
        tick(); #1;
        run_txn(3, 8'h00, "after_stall");

        // Reset while in READ discards the transaction
        bus.req_valid = 4'b0010;
        bus.req_addr  = 32'h0000_3C00;
        #1;
        chk("rstmid_req_ready", 32'(bus.req_ready), 32'(4'b0010));
        tick(); #1;
        chk("rstmid_rom_addr", 32'(bus.rom_addr), 32'h0000_003C);
        #1;
        rst_n = 1'b0;
        bus.req_valid = 4'b0000;
        #1;
        chk("rstmid_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        chk("rstmid_rom_addr0", 32'(bus.rom_addr), 32'd0);
        chk("rstmid_rsp_data", 32'(bus.rsp_data), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int s = 0; s < 4; s++) begin
            tick(); #1;
            chk("rstmid_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end
        tick();
        bus.req_valid = 4'b1111;
        bus.req_addr  = 32'h4433_2211;
        #1;
        run_txn(0, 8'h11, "post_rst0");
        #1;
        run_txn(1, 8'h22, "post_rst1");

        // Lock sequence: requester 1 locks twice, requester 2 always waiting
        bus.req_valid = 4'b0000;
        rst_n = 1'b0;
        #2;
        rst_n = 1'b1;
        tick();
        n1 = 0;
        for (int t = 0; t < 4; t++) begin
            bus.req_valid = 4'b0110;
            bus.req_addr  = 32'h0099_6600;
            bus.req_lock  = {2'b00, (n1 < 2), 1'b0};
            #1;
            run_txn(exp_lock[t], (exp_lock[t] == 1) ? 8'h66 : 8'h99, $sformatf("lock%0d", t));
            if (exp_lock[t] == 1) n1++;
        end
        bus.req_lock = 4'b0000;

        // Random traffic against a transaction-level reference model
        m_last = 2;
        phase  = 0;
        m_win  = 0;
        m_addr = 8'h00;
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NR; i++) rv[i] = ($urandom_range(0, 99) < 55);
            bus.req_valid = rv;
            bus.req_addr  = $urandom();
            bus.rsp_ready = 4'($urandom_range(0, 15));
            av = bus.req_addr;
            #1;
            if (phase == 0) begin
                win = -1;
                for (int k = 1; k <= NR; k++) begin
                    cnd = (m_last + k) % NR;
                    if (win < 0 && rv[cnd]) win = cnd;
                end
                chk("rnd_req_ready", 32'(bus.req_ready), 32'(oh(win)));
                chk("rnd_idle_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                if (win >= 0) begin
                    m_win  = win;
                    m_last = win;
                    m_addr = av[win*8 +: 8];
                    phase  = 1;
                end
            end else if (phase == 1) begin
                chk("rnd_rom_addr", 32'(bus.rom_addr), 32'(m_addr));
                chk("rnd_gnt_id", 32'(bus.gnt_id), m_win);
                chk("rnd_read_req_ready", 32'(bus.req_ready), 32'd0);
                chk("rnd_read_rsp_valid", 32'(bus.rsp_valid), 32'd0);
                phase = 2;
            end else begin
                chk("rnd_rsp_valid", 32'(bus.rsp_valid), 32'(oh(m_win)));
                chk("rnd_rsp_data", 32'(bus.rsp_data), 32'(rom_fn(m_addr)));
                chk("rnd_resp_req_ready", 32'(bus.req_ready), 32'd0);
                if (bus.rsp_ready[m_win]) phase = 0;
            end
            tick();
        end
        bus.req_valid = 4'b0000;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/rom_access_arbiter.md
# rom_access_arbiter

Shares the single combinational lookup ROM (256 x 8, address in, data out) between several requesters. Each requester issues a read through a valid/ready handshake and receives a registered response through a second valid/ready handshake. Arbitration is round-robin with a registered ROM address, so ROM output timing is decoupled from requester logic. The block sits between the project's requester FSMs and the ROM instance.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_W, 8, ROM address width
- DATA_W, 8, ROM data width
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous, active-low reset
- req_valid  input  NUM_REQ  per-requester read request
- req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i at bits [i*ADDR_W +: ADDR_W]
- req_lock  input  NUM_REQ  hold grant after this transaction (honoured only with ROM_ARB_LOCK_EN)
- req_ready  output  NUM_REQ  request accepted this cycle when valid&ready
- rsp_valid  output  NUM_REQ  one-hot, response available for requester i
- rsp_data  output  DATA_W  shared response data, meaningful for the rsp_valid bit set
- rsp_ready  input  NUM_REQ  requester accepts response
- rom_addr  output  ADDR_W  registered address to ROM
- rom_data  input  DATA_W  combinational ROM output for rom_addr
- gnt_id  output  $clog2(NUM_REQ)  index of current/last granted requester

## Operation
- FSM states: IDLE, READ, RESP.
- IDLE: rr picker selects winner among req_valid, starting at (last_grant+1) mod NUM_REQ. req_ready = one-hot winner (combinational from req_valid). On accept edge: rom_addr <= req_addr[winner], gnt_id/last_grant <= winner, -> READ. No valid requests: stay IDLE, rom_addr holds.
- READ: one cycle; rsp_data <= rom_data on the edge; -> RESP.
- RESP: rsp_valid[gnt_id]=1, rsp_data stable until rsp_ready[gnt_id]; on that edge -> IDLE. rsp_ready of other requesters ignored.
- req_ready all-zero in READ and RESP. A requester may keep req_valid high during its own RESP; it re-arbitrates in IDLE.
- req_valid may drop without acceptance; no protocol error.
- All ADDR_W-bit addresses are legal; no range checking.
- Reset values: state IDLE, rom_addr 0, rsp_data 0, rsp_valid 0, gnt_id 0, last_grant NUM_REQ-1 (requester 0 wins first). Reset mid-transaction discards it; no response is ever produced for it.

## Timing
- Accept in cycle n -> rom_addr valid cycle n+1 -> rsp_valid high from cycle n+2.
- rsp_ready high in cycle n+2 -> IDLE in n+3; minimum 3 cycles per transaction.
- ROM path: rom_addr register -> ROM -> rsp_data register, one full cycle.
- rsp_valid, rsp_data, rom_addr, gnt_id are register outputs; req_ready is combinational from req_valid and state only (never from rsp_ready).

## Configuration
- ROM_ARB_LOCK_EN defined: if req_lock[gnt_id] is high at the rsp handshake edge, a lock flag is set; in IDLE only gnt_id may be granted (others' req_ready 0), even if it has no valid request (arbiter waits). Flag clears on a rsp handshake with req_lock low. Reset clears it.
- Undefined: req_lock ignored, pure round-robin; port remains present.

## Structure
- Package rom_arb_pkg: state enum (IDLE/READ/RESP), default NUM_REQ/ADDR_W/DATA_W constants.
- Sub-module rr_picker: NUM_REQ request vector + last_grant -> one-hot grant and index, purely combinational.

## Test plan
- Requester 0 only, addr 0x10, rsp_ready=1 -> rom_addr=0x10 in cycle n+1, rsp_valid=4'b0001 in n+2, rsp_data=rom[0x10].
- All four req_valid held, rsp_ready tied high -> grant order 0,1,2,3,0, one accept every 3 cycles, each rsp_data matches its address.
- rsp_ready[2] held low 5 cycles during requester 2 response -> rsp_valid/rsp_data stable, req_ready all 0 throughout, next accept only after handshake.
- rst_n pulsed low in READ -> rsp_valid 0, rom_addr 0 immediately; next simultaneous 0..3 requests grant 0 first.
- Last grant 3, requesters 0 and 3 valid -> 0 granted; then 3.
- Requester 1 with req_lock high for 2 transactions then low, requester 2 valid throughout -> with ROM_ARB_LOCK_EN grants 1,1,1,2; without -> 1,2,1,2.
